// File: rtl/multi_addsub_seq_pkg.sv
// Shared types and helpers for the multi-operand add/sub block:
// FSM state encoding, mode constants and signed-extreme helpers.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Widest operand the helpers can describe; callers truncate to WIDTH.
  localparam int MAX_W = 64;

  // Largest positive two's-complement value of a w-bit word (0111..1).
  function automatic logic [MAX_W-1:0] smax(input int w);
    logic [MAX_W-1:0] one;
    one = {{(MAX_W-1){1'b0}}, 1'b1};
    return (one << (w - 1)) - one;
  endfunction

  // Most negative two's-complement value of a w-bit word (1000..0).
  function automatic logic [MAX_W-1:0] smin(input int w);
    logic [MAX_W-1:0] one;
    one = {{(MAX_W-1){1'b0}}, 1'b1};
    return one << (w - 1);
  endfunction

endpackage

// File: rtl/multi_addsub_seq_if.sv
// Request/response bundle of the multi-operand add/sub block.
// master drives start/mode/ops, slave returns res/ovf/busy/done.
interface multi_addsub_seq_if #(
  parameter int WIDTH = 8,
  parameter int N_OPS = 4
);

  logic                     start;
  logic                     mode;
  logic [N_OPS*WIDTH-1:0]   ops;
  logic [WIDTH-1:0]         res;
  logic                     ovf;
  logic                     busy;
  logic                     done;

  modport master (
    output start, mode, ops,
    input  res, ovf, busy, done
  );

  modport slave (
    input  start, mode, ops,
    output res, ovf, busy, done
  );

endinterface

// File: rtl/multi_addsub_seq_unit.sv
// Combinational WIDTH-bit add/subtract step with signed overflow detect.
// Optional macro SATURATE_EN: clamp the result to the signed extreme in
// the overflow direction instead of wrapping.
module addsub_unit
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  logic [WIDTH-1:0] raw;
  logic             b_sign;

`ifdef SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(smax(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(smin(WIDTH));
`endif

  // One modulo step; a subtraction overflows exactly like adding an operand
  // of the opposite sign, so the sign of b is flipped before the sign test.
  always_comb begin
    raw    = (sub == MODE_SUB) ? (a - b) : (a + b);
    b_sign = b[WIDTH-1] ^ sub;
    ovf    = (a[WIDTH-1] == b_sign) && (raw[WIDTH-1] != a[WIDTH-1]);
`ifdef SATURATE_EN
    // Overflow direction follows the sign both effective operands share.
    if (ovf) begin
      sum = a[WIDTH-1] ? SAT_MIN : SAT_MAX;
    end else begin
      sum = raw;
    end
`else
    sum = raw;
`endif
  end

endmodule

// File: rtl/multi_addsub_seq.sv
// Sequential N_OPS x WIDTH-bit add/sub chain behind a start/done handshake.
// One shared add/sub step per clock; signed overflow is sticky across steps.
// Optional macro SATURATE_EN (in addsub_unit): saturating accumulation.
module multi_addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_OPS = 4,
  parameter int IDXW  = $clog2(N_OPS)
) (
  input  logic              clock,
  input  logic              reset,
  multi_addsub_seq_if.slave bus
);

  localparam logic [IDXW-1:0] IDX_FIRST = IDXW'(1);
  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(N_OPS - 1);

  state_t           state_reg;
  logic             start_q_reg;
  logic             mode_r_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [IDXW-1:0]  idx_reg;
  logic             ovf_acc_reg;
  logic [WIDTH-1:0] res_reg;
  logic             ovf_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] op_r_reg [N_OPS];

  logic             accept;
  logic [WIDTH-1:0] step_sum;
  logic             step_ovf;

  // A request is a fresh rising edge of start seen while idle.
  assign accept = bus.start && !start_q_reg && (state_reg == IDLE);

  // Snapshot all operands on accept so later input changes cannot leak in.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_OPS; i++) begin
        op_r_reg[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < N_OPS; i++) begin
        op_r_reg[i] <= bus.ops[i*WIDTH +: WIDTH];
      end
    end
  end

  addsub_unit #(
    .WIDTH (WIDTH)
  ) u_unit (
    .a   (acc_reg),
    .b   (op_r_reg[idx_reg]),
    .sub (mode_r_reg),
    .sum (step_sum),
    .ovf (step_ovf)
  );

  // Control FSM: accept, one accumulation step per clock, one-cycle done.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      // Reset as if start were already high, so a start level held through
      // reset is not mistaken for a fresh edge; it has to drop first.
      start_q_reg <= 1'b1;
      mode_r_reg  <= MODE_ADD;
      acc_reg     <= '0;
      idx_reg     <= '0;
      ovf_acc_reg <= 1'b0;
      res_reg     <= '0;
      ovf_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      start_q_reg <= bus.start;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            mode_r_reg  <= bus.mode;
            acc_reg     <= bus.ops[WIDTH-1:0];
            idx_reg     <= IDX_FIRST;
            ovf_acc_reg <= 1'b0;
            busy_reg    <= 1'b1;
            state_reg   <= ACCUM;
          end
        end
        ACCUM: begin
          acc_reg     <= step_sum;
          ovf_acc_reg <= ovf_acc_reg | step_ovf;
          idx_reg     <= idx_reg + IDXW'(1);
          if (idx_reg == IDX_LAST) begin
            res_reg   <= step_sum;
            ovf_reg   <= ovf_acc_reg | step_ovf;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= DONE;
          end
        end
        DONE: begin
          // Start edges arriving here are dropped, not queued.
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.res  = res_reg;
  assign bus.ovf  = ovf_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;

endmodule
